// File: rtl/ilog2_arbiter_if.sv
// Bus bundle between the requesters/ilog2 pipeline (master side) and ilog2_arbiter (slave side).
interface ilog2_arbiter_if #(
    parameter int NREQ = 4
);
    logic                 en;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_v;
    logic [NREQ-1:0]      req_ready;
    logic                 pipe_issue;
    logic [31:0]          pipe_v;
    logic [4:0]           pipe_log2;
    logic [NREQ-1:0]      rsp_valid;
    logic [4:0]           rsp_log2;
    logic                 rsp_zero;
    logic [3:0]           inflight;
    logic                 idle;

    modport master (
        output en, req_valid, req_v, pipe_log2,
        input  req_ready, pipe_issue, pipe_v, rsp_valid, rsp_log2, rsp_zero, inflight, idle
    );

    modport slave (
        input  en, req_valid, req_v, pipe_log2,
        output req_ready, pipe_issue, pipe_v, rsp_valid, rsp_log2, rsp_zero, inflight, idle
    );
endinterface

// File: rtl/ilog2_arbiter.sv
// Shares one fixed-latency ilog2 pipeline among NREQ requesters, routing results back by tag.
// ILOG2_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module ilog2_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 5
) (
    input  logic           clk,
    input  logic           reset,
    ilog2_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           zero;
    } tag_t;

    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [NREQ-1:0] grant;
    logic            transfer;
    logic [31:0]     grant_v;
    logic [NREQ-1:0] rsp_onehot;
    tag_t            tag_q [0:LAT];

`ifdef ILOG2_ARB_RR_EN
    logic [IDW-1:0] ptr_q;

    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_l;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_l     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_l = IDW'(idx);
            if (!grant_any && bus.req_valid[idx_l]) begin
                grant_any = 1'b1;
                grant_id  = idx_l;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (transfer) begin
            ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end
`else
    // Scanning downward leaves the lowest asserted index as the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[IDW'(k)]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_any && bus.en && !reset) grant[grant_id] = 1'b1;
    end

    assign bus.req_ready = grant;
    assign transfer      = |grant;

    always_comb begin
        grant_v = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) grant_v = bus.req_v[32*k +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pipe_issue <= 1'b0;
            bus.pipe_v     <= '0;
        end else begin
            bus.pipe_issue <= transfer;
            if (transfer) bus.pipe_v <= grant_v;
        end
    end

    // tag_q[LAT] lines up with the cycle in which pipe_log2 carries its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: transfer, id: grant_id, zero: (grant_v == 32'd0)};
            for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[tag_q[LAT].id] = tag_q[LAT].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= '0;
            bus.rsp_log2  <= '0;
            bus.rsp_zero  <= 1'b0;
        end else begin
            bus.rsp_valid <= rsp_onehot;
            if (tag_q[LAT].valid) begin
                bus.rsp_log2 <= tag_q[LAT].zero ? 5'd0 : bus.pipe_log2;
                bus.rsp_zero <= tag_q[LAT].zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.inflight <= '0;
        end else begin
            unique case ({transfer, |bus.rsp_valid})
                2'b10:   bus.inflight <= bus.inflight + 4'd1;
                2'b01:   bus.inflight <= bus.inflight - 4'd1;
                default: bus.inflight <= bus.inflight;
            endcase
        end
    end

    assign bus.idle = (bus.inflight == 4'd0);
endmodule

// File: tb/tb_ilog2_arbiter.sv
// Scoreboard bench for ilog2_arbiter: directed stimulus pushes expected responses, a monitor checks them.
module tb_ilog2_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 5;
`ifdef ILOG2_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ilog2_arbiter_if #(.NREQ(NREQ)) bus();

    ilog2_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // External pipeline model; junk values between results and for zero operands.
    function automatic logic [4:0] flog2(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return 5'(i);
        return 5'd13;
    endfunction

    logic [4:0] pstage [LAT];
    always @(posedge clk) begin
        pstage[0] <= bus.pipe_issue ? flog2(bus.pipe_v) : 5'd21;
        for (int i = 1; i < LAT; i++) pstage[i] <= pstage[i-1];
    end
    assign bus.pipe_log2 = pstage[LAT-1];

    typedef struct {
        int         id;
        logic [4:0] l2;
        logic       z;
        int         at;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [4:0] last_l2 = '0;
    logic       last_z  = 1'b0;

    task automatic push(input int id, input logic [4:0] l2, input logic z);
        sbq.push_back(exp_t'{id, l2, z, cyc + LAT + 2});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last_l2 = '0;
            last_z  = 1'b0;
        end else if (sbq.size() > 0 && sbq[0].at == cyc) begin
            e = sbq.pop_front();
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << e.id));
            chk("rsp_log2", 64'(bus.rsp_log2), 64'(e.l2));
            chk("rsp_zero", 64'(bus.rsp_zero), 64'(e.z));
            last_l2 = e.l2;
            last_z  = e.z;
        end else begin
            chk("rsp_quiet", 64'(bus.rsp_valid), 64'd0);
            chk("rsp_hold_log2", 64'(bus.rsp_log2), 64'(last_l2));
            chk("rsp_hold_zero", 64'(bus.rsp_zero), 64'(last_z));
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drained"}, 64'(sbq.size()), 64'd0);
        chk({name, "_idle"}, 64'(bus.idle), 64'd1);
        chk({name, "_inflight"}, 64'(bus.inflight), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({name, "_pipe_issue"}, 64'(bus.pipe_issue), 64'd0);
        chk({name, "_pipe_v"}, 64'(bus.pipe_v), 64'd0);
        chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({name, "_rsp_log2"}, 64'(bus.rsp_log2), 64'd0);
        chk({name, "_rsp_zero"}, 64'(bus.rsp_zero), 64'd0);
        chk({name, "_inflight"}, 64'(bus.inflight), 64'd0);
        chk({name, "_idle"}, 64'(bus.idle), 64'd1);
    endtask

    logic [31:0] ops [4] = '{32'h1, 32'h80, 32'h1_0000, 32'h8000_0000};
    logic [4:0]  l2s [4] = '{5'd0, 5'd7, 5'd16, 5'd31};

    initial begin
        int id;
        int last_at;
        int n;
        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_v     = '0;

        // Reset state, with requests pending to show req_ready stays low.
        repeat (2) @(negedge clk);
        bus.en        = 1'b1;
        bus.req_valid = '1;
        #1 check_reset_values("reset");
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // Single request from requester 2.
        @(negedge clk);
        bus.req_v[64 +: 32] = 32'h0000_0400;
        bus.req_valid       = 4'b0100;
        #1 chk("single_ready", 64'(bus.req_ready), 64'h4);
        push(2, 5'd10, 1'b0);
        @(negedge clk);
        chk("single_ready_after", 64'(bus.req_ready), 64'h4);
        bus.req_valid = '0;
        chk("single_issue", 64'(bus.pipe_issue), 64'd1);
        chk("single_pipe_v", 64'(bus.pipe_v), 64'h400);
        chk("single_inflight", 64'(bus.inflight), 64'd1);
        chk("single_idle", 64'(bus.idle), 64'd0);
        @(negedge clk);
        chk("issue_clear", 64'(bus.pipe_issue), 64'd0);
        chk("pipe_v_hold", 64'(bus.pipe_v), 64'h400);
        drain("single");

        // Zero operand from requester 0.
        @(negedge clk);
        bus.req_v[0 +: 32] = 32'd0;
        bus.req_valid      = 4'b0001;
        #1 chk("zero_ready", 64'(bus.req_ready), 64'h1);
        push(0, 5'd0, 1'b1);
        @(negedge clk);
        bus.req_valid = '0;
        chk("zero_pipe_v", 64'(bus.pipe_v), 64'd0);
        drain("zero");

        // All four requesters valid for 8 grants.
        pulse_reset();
        for (int i = 0; i < 4; i++) bus.req_v[32*i +: 32] = ops[i];
        @(negedge clk);
        bus.en        = 1'b1;
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            id = RR ? (k % 4) : 0;
            chk("stream_ready", 64'(bus.req_ready), 64'(1 << id));
            push(id, l2s[id], 1'b0);
            @(negedge clk);
            chk("stream_inflight", 64'(bus.inflight), 64'((k + 1 > 7) ? 7 : k + 1));
        end
        bus.req_valid = '0;
        drain("stream");

        // en dropped after three grants.
        pulse_reset();
        @(negedge clk);
        bus.en        = 1'b1;
        bus.req_valid = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            id = RR ? k : 0;
            chk("en_ready", 64'(bus.req_ready), 64'(1 << id));
            push(id, l2s[id], 1'b0);
            @(negedge clk);
        end
        last_at = cyc + LAT + 1;
        bus.en  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("en_off_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        bus.req_valid = '0;
        n = 0;
        while (cyc < last_at && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("en_last_rsp_cycle", 64'(cyc), 64'(last_at));
        chk("en_not_idle_at_last", 64'(bus.idle), 64'd0);
        @(negedge clk);
        chk("en_idle_after_last", 64'(bus.idle), 64'd1);
        drain("en");

        // Reset three cycles after two grants discards both.
        @(negedge clk);
        bus.en              = 1'b1;
        bus.req_v[32 +: 32] = 32'd7;
        bus.req_valid       = 4'b0010;
        @(negedge clk);
        bus.req_v[96 +: 32] = 32'h100;
        bus.req_valid       = 4'b1000;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        chk("rst_mid_inflight", 64'(bus.inflight), 64'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        bus.req_valid = '1;
        #1 check_reset_values("rst_mid");
        bus.req_valid = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_mid_after_inflight", 64'(bus.inflight), 64'd0);
        chk("rst_mid_after_idle", 64'(bus.idle), 64'd1);
        chk("rst_mid_queue", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
